// File: rtl/fanout_arb_pkg.sv
// Shared definitions for the fanout arbiter: FSM encoding and default sizing.
package fanout_arb_pkg;

    // Arbiter FSM states; the encoding is part of the block's contract.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Default parameter values for the arbiter.
    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 16;
    localparam int BURST_MAX_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of i_req at or above
// i_rr_ptr, wrapping past the top index. NREQ is a power of two, so the
// wrap is plain truncation of the index sum.
module rr_pick
    import fanout_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic            o_found,
    output logic [IW-1:0]   o_index
);

    logic [IW-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = i_rr_ptr + IW'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_index = w_cand;
            end
        end
    end

endmodule

// File: rtl/fanout_arb.sv
// Burst arbiter in front of the fanout block. One requester is granted at a
// time and streams up to BURST_MAX beats; the accepted beat is registered and
// presented on data_v/out_data, which feed the fanout directly.
//
// Handshake: a requester beat transfers in a cycle where req_v[i] and
// req_rdy[i] are both high; req_rdy is only ever high for the granted
// requester while in BURST and halt is low. Downstream consumes out_data in
// a cycle where data_v is high and halt is low; while halt is high, data_v
// and out_data hold.
module fanout_arb
    import fanout_arb_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int DW        = DW_DEF,
    parameter  int BURST_MAX = BURST_MAX_DEF,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_v,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_rdy,
    input  logic               halt,
    output logic               data_v,
    output logic [DW-1:0]      out_data,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    localparam int CW = $clog2(BURST_MAX + 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_grant_id;
    logic [IW-1:0] r_rr_ptr;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_data_v;
    logic [DW-1:0] r_out_data;

    logic          w_found;
    logic [IW-1:0] w_pick;
    logic          w_xfer;
    logic          w_last_beat;
    logic          w_start;
    logic          w_exit;
    logic [DW-1:0] w_beat;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (req_v),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_index  (w_pick)
    );

    assign w_xfer      = (r_state == ST_BURST) && !halt && req_v[r_grant_id];
    assign w_beat      = req_data[int'(r_grant_id) * DW +: DW];
    assign w_cnt_inc   = r_beat_cnt + CW'(1);
    // The beat that reaches BURST_MAX closes the burst even without last.
    assign w_last_beat = req_last[r_grant_id] || (w_cnt_inc == CW'(BURST_MAX));

    // Ready goes only to the granted requester, and only when not stalled.
    always_comb begin
        req_rdy = '0;
        if ((r_state == ST_BURST) && !halt) begin
            req_rdy[r_grant_id] = 1'b1;
        end
    end

    // Next-state logic: halt freezes everything; an empty granted lane abandons.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_exit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!halt && w_found) begin
                    w_start      = 1'b1;
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!halt) begin
                    if (!req_v[r_grant_id] || w_last_beat) begin
                        w_exit       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant, round-robin pointer and beat counter bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_start) begin
                r_grant_id <= w_pick;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= w_cnt_inc;
            end
            if (w_exit) begin
                r_rr_ptr <= r_grant_id + IW'(1);
            end
        end
    end

    // Output beat register; holds under halt like the fanout input stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_v   <= 1'b0;
            r_out_data <= '0;
        end else if (!halt) begin
            r_data_v <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_beat;
            end
        end
    end

    assign data_v   = r_data_v;
    assign out_data = r_out_data;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == ST_BURST);

endmodule

// File: tb/tb_fanout_arb.sv
// Bench for fanout_arb: per-requester beat sources, an output scoreboard of
// expected beats and grant order, and one task per scenario.
module tb_fanout_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int BMAX = 8;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_v;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_rdy;
    logic               halt;
    logic               data_v;
    logic [DW-1:0]      out_data;
    logic [IW-1:0]      grant_id;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [IW-1:0] exp_grant_q[$];

    logic [DW:0]     src_mem[NREQ][32];
    int              src_rd[NREQ];
    int              src_wr[NREQ];
    logic [NREQ-1:0] acc;
    logic            halt_nxt;
    logic            busy_prev;

    fanout_arb #(
        .NREQ      (NREQ),
        .DW        (DW),
        .BURST_MAX (BMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_v    (req_v),
        .req_data (req_data),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .halt     (halt),
        .data_v   (data_v),
        .out_data (out_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_src(input int r, input logic [DW-1:0] d, input logic l);
        src_mem[r][src_wr[r]] = {l, d};
        src_wr[r]++;
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_v[i]              = 1'b1;
                req_data[i*DW +: DW]  = src_mem[i][src_rd[i]][DW-1:0];
                req_last[i]           = src_mem[i][src_rd[i]][DW];
            end else begin
                req_v[i]              = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = DW'($urandom_range(0, 65535));
            end
        end
    endtask

    // Scoreboard: consume a beat when data_v && !halt; check grant on busy rise.
    task automatic monitor();
        logic [DW-1:0] e;
        logic [IW-1:0] g;
        if (data_v === 1'b1 && !halt) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got %h, none expected", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL beat_data: got %h expected %h", out_data, e);
                end
            end
        end
        if (busy === 1'b1 && !busy_prev) begin
            checks++;
            if (exp_grant_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got grant %0d, none expected", grant_id);
            end else begin
                g = exp_grant_q.pop_front();
                if (grant_id !== g) begin
                    errors++;
                    $display("FAIL grant_order: got %0d expected %0d", grant_id, g);
                end
            end
        end
        busy_prev = busy;
    endtask

    // One clock: update sources after the edge, then sample at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) src_rd[i]++;
        end
        halt = halt_nxt;
        drive_srcs();
        @(negedge clk);
        monitor();
        acc = req_v & req_rdy;
    endtask

    task automatic assert_reset();
        rst       = 1'b0;
        halt      = 1'b0;
        halt_nxt  = 1'b0;
        acc       = '0;
        busy_prev = 1'b0;
        req_v     = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        exp_q.delete();
        exp_grant_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: beats left %0d grants left %0d, expected 0 and 0",
                     name, exp_q.size(), exp_grant_q.size());
        end
    endtask

    task automatic test_reset();
        assert_reset();
        req_data = {NREQ{16'hA5C3}};
        req_v    = '1;
        @(negedge clk);
        checks++; if (data_v !== 1'b0)   begin errors++; $display("FAIL reset_data_v: got %b expected 0", data_v); end
        checks++; if (out_data !== '0)   begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++; if (grant_id !== '0)   begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_rdy !== '0)    begin errors++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy); end
        req_v = '0;
        release_reset();
        repeat (2) begin
            cycle();
            checks++; if (busy !== 1'b0 || data_v !== 1'b0) begin errors++; $display("FAIL reset_quiet: got busy %b data_v %b expected 0 0", busy, data_v); end
        end
    endtask

    task automatic test_single();
        do_reset();
        push_src(0, 16'h0011, 1'b0);
        push_src(0, 16'h0022, 1'b0);
        push_src(0, 16'h0033, 1'b1);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h0033);
        exp_grant_q.push_back(2'd0);
        cycle(); // c0: req_v rises
        checks++; if (data_v !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_c0: got data_v %b busy %b expected 0 0", data_v, busy); end
        cycle(); // c1: burst, first beat accepted
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL single_c1_dv: got %b expected 0", data_v); end
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL single_rdy: got %b expected 0001", req_rdy); end
        for (int c = 2; c <= 4; c++) begin
            cycle();
            checks++; if (data_v !== 1'b1) begin errors++; $display("FAIL single_dv_c%0d: got %b expected 1", c, data_v); end
            if (c == 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c3: got %b expected 1", busy); end
            end
            if (c == 4) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c4: got %b expected 0", busy); end
            end
        end
        // Pointer now sits at 1: with 0 and 1 both requesting, 1 goes first.
        push_src(0, 16'h0044, 1'b1);
        push_src(1, 16'h0144, 1'b1);
        exp_grant_q.push_back(2'd1);
        exp_grant_q.push_back(2'd0);
        exp_q.push_back(16'h0144);
        exp_q.push_back(16'h0044);
        cycle(); // c5
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL single_c5_dv: got %b expected 0", data_v); end
        repeat (8) cycle();
        check_drained("single");
    endtask

    task automatic test_fairness();
        logic [DW-1:0] d;
        logic          exp_dv;
        do_reset();
        for (int b = 0; b < 5; b++) begin
            exp_grant_q.push_back(IW'(b % NREQ));
            for (int k = 0; k < 2; k++) begin
                d = DW'($urandom_range(0, 65535));
                push_src(b % NREQ, d, k == 1);
                exp_q.push_back(d);
            end
        end
        for (int c = 0; c <= 16; c++) begin
            cycle();
            exp_dv = (c >= 2) && (((c - 2) % 3) != 2);
            checks++;
            if (data_v !== exp_dv) begin
                errors++;
                $display("FAIL fair_dv_c%0d: got %b expected %b", c, data_v, exp_dv);
            end
        end
        repeat (3) cycle();
        check_drained("fair");
    endtask

    task automatic test_burst_max();
        logic [DW-1:0] d2[12];
        logic [DW-1:0] d3[2];
        // Only requester 2: capped at 8 beats, then re-granted for the rest.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            d2[k] = DW'($urandom_range(0, 65535));
            push_src(2, d2[k], 1'b0);
            exp_q.push_back(d2[k]);
        end
        exp_grant_q.push_back(2'd2);
        exp_grant_q.push_back(2'd2);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (c == 8) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bmax_busy_c8: got %b expected 1", busy); end
            end
            if (c == 9) begin
                checks++; if (busy !== 1'b0 || data_v !== 1'b1) begin errors++; $display("FAIL bmax_exit_c9: got busy %b data_v %b expected 0 1", busy, data_v); end
            end
            if (c == 10) begin
                checks++; if (busy !== 1'b1 || data_v !== 1'b0) begin errors++; $display("FAIL bmax_bubble_c10: got busy %b data_v %b expected 1 0", busy, data_v); end
            end
        end
        check_drained("bmax_solo");
        // Requester 3 waiting as well: it gets the grant after the cap.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            d2[k] = DW'($urandom_range(0, 65535));
            push_src(2, d2[k], 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            d3[k] = DW'($urandom_range(0, 65535));
            push_src(3, d3[k], k == 1);
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(d2[k]);
        for (int k = 0; k < 2; k++) exp_q.push_back(d3[k]);
        for (int k = 8; k < 12; k++) exp_q.push_back(d2[k]);
        exp_grant_q.push_back(2'd2);
        exp_grant_q.push_back(2'd3);
        exp_grant_q.push_back(2'd2);
        repeat (30) cycle();
        check_drained("bmax_rr");
    endtask

    task automatic test_halt();
        do_reset();
        push_src(0, 16'h00AA, 1'b0);
        push_src(0, 16'h00AB, 1'b0);
        push_src(0, 16'h00AC, 1'b0);
        push_src(0, 16'h00AD, 1'b1);
        exp_q.push_back(16'h00AA);
        exp_q.push_back(16'h00AB);
        exp_q.push_back(16'h00AC);
        exp_q.push_back(16'h00AD);
        exp_grant_q.push_back(2'd0);
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (c == 2) halt_nxt = 1'b1;
            if (c == 5) halt_nxt = 1'b0;
            if (c >= 3 && c <= 5) begin
                checks++; if (data_v !== 1'b1)      begin errors++; $display("FAIL halt_dv_c%0d: got %b expected 1", c, data_v); end
                checks++; if (out_data !== 16'h00AB) begin errors++; $display("FAIL halt_data_c%0d: got %h expected 00ab", c, out_data); end
                checks++; if (req_rdy !== '0)        begin errors++; $display("FAIL halt_rdy_c%0d: got %b expected 0000", c, req_rdy); end
                checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL halt_busy_c%0d: got %b expected 1", c, busy); end
            end
        end
        check_drained("halt");
    endtask

    task automatic test_abandon_reset();
        do_reset();
        push_src(1, 16'h0101, 1'b0);
        exp_q.push_back(16'h0101);
        exp_grant_q.push_back(2'd1);
        cycle(); // c0
        cycle(); // c1: beat accepted
        cycle(); // c2: requester 1 has gone quiet
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abandon_busy_c2: got %b expected 1", busy); end
        cycle(); // c3
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abandon_busy_c3: got %b expected 0", busy); end
        // Pointer now at 2: requester 2 beats requester 0.
        push_src(0, 16'h0001, 1'b1);
        push_src(2, 16'h2201, 1'b0);
        push_src(2, 16'h2202, 1'b0);
        push_src(2, 16'h2203, 1'b1);
        exp_grant_q.push_back(2'd2);
        exp_q.push_back(16'h2201);
        cycle(); // c4
        cycle(); // c5: grant 2, first beat accepted
        cycle(); // c6: 0x2201 on the output, 0x2202 being accepted
        check_drained("abandon");
        assert_reset();
        #1;
        checks++; if (data_v !== 1'b0)  begin errors++; $display("FAIL midrst_data_v: got %b expected 0", data_v); end
        checks++; if (out_data !== '0)  begin errors++; $display("FAIL midrst_out_data: got %h expected 0000", out_data); end
        checks++; if (grant_id !== '0)  begin errors++; $display("FAIL midrst_grant_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (req_rdy !== '0)   begin errors++; $display("FAIL midrst_req_rdy: got %b expected 0000", req_rdy); end
        release_reset();
        // Arbitration restarts from 0: requester 1 is the lowest requesting.
        push_src(1, 16'h0111, 1'b1);
        push_src(3, 16'h0333, 1'b1);
        exp_grant_q.push_back(2'd1);
        exp_grant_q.push_back(2'd3);
        exp_q.push_back(16'h0111);
        exp_q.push_back(16'h0333);
        repeat (12) cycle();
        check_drained("post_reset");
    endtask

    initial begin
        rst      = 1'b0;
        halt     = 1'b0;
        halt_nxt = 1'b0;
        req_v    = '0;
        req_last = '0;
        req_data = '0;
        acc      = '0;
        busy_prev = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_burst_max();
        test_halt();
        test_abandon_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fanout_arb.md
FANOUT_ARB -- requirements
Module: fanout_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (power of two, 2..8).
REQ-002 Parameter DW, default 16: data width per beat; it matches the fanout input width.
REQ-003 Parameter BURST_MAX, default 8: maximum beats per grant (1..255).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 req_v  in  NREQ  per-requester beat valid.
REQ-007 req_data  in  NREQ*DW  per-requester beat; requester i occupies bits [i*DW +: DW].
REQ-008 req_last  in  NREQ  per-requester last beat of burst, qualified by req_v.
REQ-009 req_rdy  out  NREQ  per-requester beat accepted this cycle.
REQ-010 halt  in  1  downstream stall; the same signal drives the fanout halt.
REQ-011 data_v  out  1  registered beat valid; drives the fanout data_v.
REQ-012 out_data  out  DW  registered beat; drives the fanout in_data.
REQ-013 grant_id  out  clog2(NREQ)  index of the current or last granted requester.
REQ-014 busy  out  1  high while in the BURST state.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with halt=0 and any req_v high, it SHALL select the first requester with req_v high, searching from rr_ptr upward with wrap, register it in grant_id, clear beat_cnt, and enter BURST on the next cycle.
REQ-017 In IDLE with halt=1, the FSM, grant_id and rr_ptr SHALL all hold; no arbitration occurs.
REQ-018 req_rdy[i] SHALL equal (state==BURST && grant_id==i && !halt), combinationally; all other bits are 0.
REQ-019 A transfer occurs when req_v[grant_id] && req_rdy[grant_id]; beat_cnt SHALL then increment by 1.
REQ-020 With halt=0, data_v SHALL be registered as the transfer flag; out_data SHALL load the granted beat on a transfer and hold otherwise.
REQ-021 With halt=1, data_v and out_data SHALL hold their values, matching the fanout hold semantics.
REQ-022 Input-to-output latency SHALL be 1 cycle (transfer in cycle N gives data_v=1 in cycle N+1).
REQ-023 BURST SHALL exit to IDLE after a transfer with req_last=1.
REQ-024 BURST SHALL also exit to IDLE after the transfer that brings beat_cnt to BURST_MAX.
REQ-025 BURST SHALL also exit to IDLE in any cycle with halt=0 and req_v[grant_id]=0 (abandon; no beat).
REQ-026 On every BURST exit, rr_ptr SHALL become grant_id+1 modulo NREQ.
REQ-027 While halt=1 in BURST, the state, beat_cnt and grant SHALL hold; no exit occurs.
REQ-028 There is 1 idle cycle (data_v=0) between consecutive bursts; this bubble is by design.
REQ-029 Changes on req_v or req_data of non-granted requesters SHALL have no effect during BURST.
REQ-030 beat_cnt SHALL be clog2(BURST_MAX+1) bits wide and never wrap (REQ-024 exits first).

Reset
REQ-031 rst=0 SHALL asynchronously force: state=IDLE, data_v=0, out_data=0, grant_id=0, rr_ptr=0, beat_cnt=0, busy=0, req_rdy=0.
REQ-032 Reset mid-burst SHALL discard the burst; after release, arbitration restarts from requester 0 and no partial beat is emitted.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=0, BURST=1) and the default parameter constants.
REQ-034 The round-robin priority pick SHALL be a combinational sub-module rr_pick (inputs: req vector, rr_ptr; outputs: found, index).
REQ-035 fanout_arb SHALL connect directly to the fanout block's data_v, in_data and halt inputs with no glue logic.

Verification
REQ-036 Single requester: req 0 sends 3 beats 0x0011, 0x0022, 0x0033 with last on the 3rd -> data_v high for 3 consecutive cycles starting 2 cycles after the first req_v; busy falls; rr_ptr=1.
REQ-037 Fairness: all 4 requesters hold req_v with 2-beat bursts -> grant order 0,1,2,3,0; exactly one bubble between bursts.
REQ-038 BURST_MAX: req 2 streams 12 beats with no last -> 8 beats output, then IDLE; next grant goes to req 3 (if requesting), else req 2 again.
REQ-039 Halt: halt=1 for 3 cycles mid-burst with out_data=0x00AB -> data_v and out_data hold 0x00AB; req_rdy=0; no beats lost or duplicated after release.
REQ-040 Abandon and reset: req 1 drops req_v after 1 beat -> IDLE next cycle and rr_ptr=2; rst pulsed mid-burst -> all outputs 0 immediately, next grant goes to the lowest requesting index.
